csc_rgb2ycbcr: RTL and testbench

Parametrised, fully pipelined RGB→YCbCr colour-space converter for the HDMI video path. It sits between the HDMI receiver/RGB source and the YCbCr consumers. It generalises the fixed 8-bit BT.601 converter in four ways: configurable component width, selectable BT.601/BT.709 matrix, full or limited output range, and round-to-nearest with saturation. The standard and range selection switches only at frame boundaries, and hs/vs/de are delay-matched to the pixel path.

---
 rtl/csc_rgb2ycbcr.sv | 254 +++++++++++++++++++++++++
 tb/tb_csc_rgb2ycbcr.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csc_rgb2ycbcr.sv
// csc_rgb2ycbcr: four-stage pipelined RGB to YCbCr converter for the HDMI path.
// DW-bit components, BT.601/BT.709 matrices, full or limited output range,
// round-to-nearest and saturation. The matrix and range selection is latched on
// the rising edge of vsync. Each pixel carries the mode it was sampled with, so
// all three of its channels use the same coefficient set.
`timescale 1ns/1ps

module csc_rgb2ycbcr #(
  parameter int DW     = 8,
  parameter int COEF_W = 18,
  parameter int FRAC   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] r,
  input  logic [DW-1:0] g,
  input  logic [DW-1:0] b,
  input  logic          hdmi_hs_in,
  input  logic          hdmi_vs_in,
  input  logic          de_in,
  input  logic          std_sel,
  input  logic          range_sel,
  output logic [DW-1:0] y,
  output logic [DW-1:0] cb,
  output logic [DW-1:0] cr,
  output logic          hdmi_hs_out,
  output logic          hdmi_vs_out,
  output logic          de_out,
  output logic [1:0]    mode_active
);

  // A product holds a zero-extended component times a signed coefficient.
  // The channel sum adds two guard bits so that three products plus the
  // offset and the rounding constant cannot overflow.
  localparam int PW = DW + 1 + COEF_W;
  localparam int SW = PW + 2;

  localparam logic signed [SW-1:0] OFF_Y_LIM = SW'(16 << (DW - 8)) <<< FRAC;
  localparam logic signed [SW-1:0] OFF_C     = SW'(1 << (DW - 1)) <<< FRAC;
  localparam logic signed [SW-1:0] RND       = SW'(1) <<< (FRAC - 1);
  localparam logic signed [SW-1:0] MAX_V     = SW'((1 << DW) - 1);

  // Coefficient for set setIdx ({range, std}) and position idx
  // (Y:r,g,b, Cb:r,g,b, Cr:r,g,b), rounded to nearest, half away from zero.
  // The limited-range scaling is applied before rounding.
  function automatic int coefVal(input int setIdx, input int idx);
    real base;
    real scale;
    real v;
    bit  isBt709;
    bit  isLimited;
    isBt709   = (setIdx % 2) != 0;
    isLimited = (setIdx / 2) != 0;
    case (idx)
      0:       base = isBt709 ?  0.2126   :  0.299;
      1:       base = isBt709 ?  0.7152   :  0.587;
      2:       base = isBt709 ?  0.0722   :  0.114;
      3:       base = isBt709 ? -0.114572 : -0.168736;
      4:       base = isBt709 ? -0.385428 : -0.331264;
      5:       base = 0.5;
      6:       base = 0.5;
      7:       base = isBt709 ? -0.454153 : -0.418688;
      8:       base = isBt709 ? -0.045847 : -0.081312;
      default: base = 0.0;
    endcase
    if (isLimited) begin
      scale = (idx < 3) ? (219.0 / 255.0) : (224.0 / 255.0);
    end else begin
      scale = 1.0;
    end
    v = base * scale;
    for (int i = 0; i < FRAC; i++) begin
      v = v * 2.0;
    end
    if (v >= 0.0) begin
      return $rtoi(v + 0.5);
    end
    return -$rtoi(0.5 - v);
  endfunction

  // The four coefficient sets are fixed when the design is built.
  logic signed [COEF_W-1:0] coefTab [4][9];

  for (genvar gs = 0; gs < 4; gs++) begin : g_set
    for (genvar gi = 0; gi < 9; gi++) begin : g_coef
      localparam int KV = coefVal(gs, gi);
      assign coefTab[gs][gi] = KV[COEF_W-1:0];
    end
  end

  // Mode register and the previous vsync level used to find its rising edge.
  logic [1:0] mode_q;
  logic [1:0] mode_d;
  logic       vsPrev_q;

  // Stage 1: sampled pixel, syncs {hs, vs, de}, per-pixel mode tag.
  logic [DW-1:0] s1R_q, s1G_q, s1B_q;
  logic [2:0]    s1Sync_q;
  logic [1:0]    s1Tag_q;
  logic          s1V_q;

  // Stage 2: nine products.
  logic signed [DW:0]   compS  [3];
  logic signed [PW-1:0] prod_d [9];
  logic signed [PW-1:0] prod_q [9];
  logic [2:0]           s2Sync_q;
  logic [1:0]           s2Tag_q;
  logic                 s2V_q;

  // Stage 3: per-channel sums including offset and rounding constant.
  logic signed [SW-1:0] offY;
  logic signed [SW-1:0] sum_d [3];
  logic signed [SW-1:0] sum_q [3];
  logic [2:0]           s3Sync_q;
  logic                 s3V_q;

  // Stage 4: shifted, saturated outputs.
  logic signed [SW-1:0] shifted [3];
  logic [DW-1:0]        pix_d   [3];
  logic [DW-1:0]        pix_q   [3];
  logic [2:0]           s4Sync_q;

  // A new selection is taken only on the rising edge of vsync.
  always_comb begin
    mode_d = mode_q;
    if (hdmi_vs_in && !vsPrev_q) begin
      mode_d = {range_sel, std_sel};
    end
  end

  // Mode register and vsync edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= 2'b00;
      vsPrev_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      vsPrev_q <= hdmi_vs_in;
    end
  end

  // Stage 1 samples the pixel with the mode in force before this edge, so a
  // pixel sampled on the vsync edge still uses the old mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1R_q    <= '0;
      s1G_q    <= '0;
      s1B_q    <= '0;
      s1Sync_q <= '0;
      s1Tag_q  <= '0;
      s1V_q    <= 1'b0;
    end else begin
      s1R_q    <= r;
      s1G_q    <= g;
      s1B_q    <= b;
      s1Sync_q <= {hdmi_hs_in, hdmi_vs_in, de_in};
      s1Tag_q  <= mode_q;
      s1V_q    <= 1'b1;
    end
  end

  // Components are made signed by zero extension, then multiplied by the
  // coefficients of the set named by the pixel's own tag.
  always_comb begin
    compS[0] = $signed({1'b0, s1R_q});
    compS[1] = $signed({1'b0, s1G_q});
    compS[2] = $signed({1'b0, s1B_q});
    for (int i = 0; i < 9; i++) begin
      prod_d[i] = PW'(compS[i % 3]) * PW'(coefTab[s1Tag_q][i]);
    end
  end

  // Stage 2 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        prod_q[i] <= '0;
      end
      s2Sync_q <= '0;
      s2Tag_q  <= '0;
      s2V_q    <= 1'b0;
    end else begin
      prod_q   <= prod_d;
      s2Sync_q <= s1Sync_q;
      s2Tag_q  <= s1Tag_q;
      s2V_q    <= s1V_q;
    end
  end

  // Per-channel sum. Only the luma offset depends on the range; the chroma
  // offset is mid-scale in both ranges.
  always_comb begin
    offY = s2Tag_q[1] ? OFF_Y_LIM : '0;
    sum_d[0] = SW'(prod_q[0]) + SW'(prod_q[1]) + SW'(prod_q[2]) + offY  + RND;
    sum_d[1] = SW'(prod_q[3]) + SW'(prod_q[4]) + SW'(prod_q[5]) + OFF_C + RND;
    sum_d[2] = SW'(prod_q[6]) + SW'(prod_q[7]) + SW'(prod_q[8]) + OFF_C + RND;
  end

  // Stage 3 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        sum_q[i] <= '0;
      end
      s3Sync_q <= '0;
      s3V_q    <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      s3Sync_q <= s2Sync_q;
      s3V_q    <= s2V_q;
    end
  end

  // Drop the fraction and clamp to the code range. Stages that hold only the
  // reset state produce 0 rather than the offset of a black pixel, so the
  // outputs stay 0 until real data arrives after reset.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      shifted[i] = sum_q[i] >>> FRAC;
      pix_d[i]   = '0;
      if (s3V_q) begin
        if (shifted[i][SW-1]) begin
          pix_d[i] = '0;
        end else if (shifted[i] > MAX_V) begin
          pix_d[i] = MAX_V[DW-1:0];
        end else begin
          pix_d[i] = shifted[i][DW-1:0];
        end
      end
    end
  end

  // Stage 4 output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        pix_q[i] <= '0;
      end
      s4Sync_q <= '0;
    end else begin
      pix_q    <= pix_d;
      s4Sync_q <= s3Sync_q;
    end
  end

  assign y           = pix_q[0];
  assign cb          = pix_q[1];
  assign cr          = pix_q[2];
  assign hdmi_hs_out = s4Sync_q[2];
  assign hdmi_vs_out = s4Sync_q[1];
  assign de_out      = s4Sync_q[0];
  assign mode_active = mode_q;

endmodule

// File: tb/tb_csc_rgb2ycbcr.sv
// tb_csc_rgb2ycbcr: scoreboard bench for csc_rgb2ycbcr. Every sampled pixel
// pushes its modelled result (and optional hand-derived values) onto a queue,
// which is popped when that pixel reaches the outputs four clocks later. A
// second DW=10 instance gets a few directed pixels.
`timescale 1ns/1ps

module tb_csc_rgb2ycbcr;

  typedef struct {
    int   y, cb, cr;
    int   hs, vs, de;
    logic dirValid;
    int   dy, dcb, dcr;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [7:0] r, g, b;
  logic       hs, vs, de, stdSel, rangeSel;
  logic [7:0] y, cb, cr;
  logic       hsOut, vsOut, deOut;
  logic [1:0] modeActive;

  logic [9:0] r10, g10, b10;
  logic       hs10, vs10, de10, std10, range10;
  logic [9:0] y10, cb10, cr10;
  logic       hsOut10, vsOut10, deOut10;
  logic [1:0] modeActive10;

  logic       dirValid;
  int         dirY, dirCb, dirCr;

  entry_t     sbq [$];
  logic [1:0] modelMode;
  logic       modelVsPrev;

  int vectorCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  csc_rgb2ycbcr #(.DW(8), .COEF_W(18), .FRAC(16)) dut (
    .clk(clk), .rst_n(rst_n), .r(r), .g(g), .b(b),
    .hdmi_hs_in(hs), .hdmi_vs_in(vs), .de_in(de),
    .std_sel(stdSel), .range_sel(rangeSel),
    .y(y), .cb(cb), .cr(cr),
    .hdmi_hs_out(hsOut), .hdmi_vs_out(vsOut), .de_out(deOut),
    .mode_active(modeActive)
  );

  csc_rgb2ycbcr #(.DW(10), .COEF_W(18), .FRAC(16)) dut10 (
    .clk(clk), .rst_n(rst_n), .r(r10), .g(g10), .b(b10),
    .hdmi_hs_in(hs10), .hdmi_vs_in(vs10), .de_in(de10),
    .std_sel(std10), .range_sel(range10),
    .y(y10), .cb(cb10), .cr(cr10),
    .hdmi_hs_out(hsOut10), .hdmi_vs_out(vsOut10), .de_out(deOut10),
    .mode_active(modeActive10)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, want %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference conversion straight from the matrix definitions.
  function automatic void modelPixel(input int dw, input logic [1:0] mode,
                                     input int rv, input int gv, input int bv,
                                     output int ey, output int ecb, output int ecr);
    real    base [2][9];
    real    scale, v;
    longint k [9];
    longint acc, offY, offC, maxV;
    int     res [3];
    base[0] = '{0.299, 0.587, 0.114, -0.168736, -0.331264, 0.5, 0.5, -0.418688, -0.081312};
    base[1] = '{0.2126, 0.7152, 0.0722, -0.114572, -0.385428, 0.5, 0.5, -0.454153, -0.045847};
    for (int i = 0; i < 9; i++) begin
      scale = mode[1] ? ((i < 3) ? 219.0 / 255.0 : 224.0 / 255.0) : 1.0;
      v = base[mode[0]][i] * scale * 65536.0;
      k[i] = (v < 0.0) ? -longint'($rtoi(-v + 0.5)) : longint'($rtoi(v + 0.5));
    end
    offY = mode[1] ? longint'(16 << (dw - 8)) : 0;
    offC = longint'(1 << (dw - 1));
    maxV = longint'((1 << dw) - 1);
    for (int ch = 0; ch < 3; ch++) begin
      acc = k[3*ch] * rv + k[3*ch+1] * gv + k[3*ch+2] * bv
            + (((ch == 0) ? offY : offC) << 16) + 32768;
      acc = acc >>> 16;
      if (acc < 0) res[ch] = 0;
      else if (acc > maxV) res[ch] = int'(maxV);
      else res[ch] = int'(acc);
    end
    ey  = res[0];
    ecb = res[1];
    ecr = res[2];
  endfunction

  task automatic applyStimulus(input int rv, input int gv, input int bv,
                               input logic [2:0] syncV, input logic [1:0] selV,
                               input logic dv = 1'b0, input int ey = 0,
                               input int ecb = 0, input int ecr = 0);
    @(negedge clk);
    r        = rv[7:0];
    g        = gv[7:0];
    b        = bv[7:0];
    hs       = syncV[2];
    vs       = syncV[1];
    de       = syncV[0];
    rangeSel = selV[1];
    stdSel   = selV[0];
    dirValid = dv;
    dirY     = ey;
    dirCb    = ecb;
    dirCr    = ecr;
  endtask

  // Model side: each sampling edge queues the expected result for the pixel
  // the DUT just took, then applies the vsync mode update.
  initial begin
    entry_t e;
    modelMode   = 2'b00;
    modelVsPrev = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        sbq.delete();
        modelMode   = 2'b00;
        modelVsPrev = 1'b0;
      end else begin
        modelPixel(8, modelMode, int'(r), int'(g), int'(b), e.y, e.cb, e.cr);
        e.hs       = int'(hs);
        e.vs       = int'(vs);
        e.de       = int'(de);
        e.dirValid = dirValid;
        e.dy       = dirY;
        e.dcb      = dirCb;
        e.dcr      = dirCr;
        sbq.push_back(e);
        if (vs && !modelVsPrev) modelMode = {rangeSel, stdSel};
        modelVsPrev = vs;
      end
    end
  end

  // Output side: compare on the falling edge, away from the DUT's updates.
  initial begin
    entry_t c;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checkOutput("rst_y", y, 0);
        checkOutput("rst_cb", cb, 0);
        checkOutput("rst_cr", cr, 0);
        checkOutput("rst_de", deOut, 0);
        checkOutput("rst_hs", hsOut, 0);
        checkOutput("rst_vs", vsOut, 0);
        checkOutput("rst_mode", modeActive, 0);
      end else if (sbq.size() >= 4) begin
        c = sbq.pop_front();
        checkOutput("y", y, c.y);
        checkOutput("cb", cb, c.cb);
        checkOutput("cr", cr, c.cr);
        checkOutput("hs", hsOut, c.hs);
        checkOutput("vs", vsOut, c.vs);
        checkOutput("de", deOut, c.de);
        checkOutput("mode", modeActive, modelMode);
        if (c.dirValid) begin
          checkOutput("dir_y", y, c.dy);
          checkOutput("dir_cb", cb, c.dcb);
          checkOutput("dir_cr", cr, c.dcr);
        end
      end else begin
        checkOutput("fill_y", y, 0);
        checkOutput("fill_cb", cb, 0);
        checkOutput("fill_cr", cr, 0);
        checkOutput("fill_de", deOut, 0);
        checkOutput("fill_mode", modeActive, modelMode);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] curSel;
    logic [2:0] walk;
    int         ey, ecb, ecr;

    rst_n = 1'b1;
    {r, g, b} = '0;
    {hs, vs, de, stdSel, rangeSel} = '0;
    {r10, g10, b10} = '0;
    {hs10, vs10, de10, std10, range10} = '0;
    dirValid = 1'b0;
    dirY = 0; dirCb = 0; dirCr = 0;
    #1 rst_n = 1'b0;
    $display("[TB] reset asserted");

    // Busy inputs while in reset must not reach the outputs.
    repeat (3) applyStimulus(255, 255, 255, 3'b111, 2'b00);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // BT.601 full range.
    applyStimulus(255, 255, 255, 3'b001, 2'b00, 1'b1, 255, 128, 128);
    applyStimulus(255, 0, 0, 3'b001, 2'b00, 1'b1, 76, 85, 255);
    applyStimulus(0, 0, 0, 3'b001, 2'b00, 1'b1, 0, 128, 128);
    applyStimulus(12, 200, 90, 3'b101, 2'b00);
    applyStimulus(0, 0, 255, 3'b001, 2'b00);

    // Limited range: the pixel on the vsync edge is still full range.
    applyStimulus(0, 0, 0, 3'b011, 2'b10, 1'b1, 0, 128, 128);
    applyStimulus(0, 0, 0, 3'b011, 2'b10, 1'b1, 16, 128, 128);
    applyStimulus(255, 255, 255, 3'b001, 2'b10, 1'b1, 235, 128, 128);
    applyStimulus(40, 120, 250, 3'b001, 2'b10);

    // Back to BT.601 full range.
    applyStimulus(0, 0, 0, 3'b011, 2'b00);
    applyStimulus(0, 0, 0, 3'b001, 2'b00, 1'b1, 0, 128, 128);

    // A mid-frame std_sel change is ignored until the next vsync rise.
    applyStimulus(0, 255, 0, 3'b001, 2'b01, 1'b1, 150, 44, 21);
    applyStimulus(0, 255, 0, 3'b001, 2'b01, 1'b1, 150, 44, 21);
    checkOutput("mode_mid_frame", modeActive, 2'b00);
    applyStimulus(0, 255, 0, 3'b011, 2'b01, 1'b1, 150, 44, 21);
    applyStimulus(0, 255, 0, 3'b001, 2'b01, 1'b1, 182, 30, 12);
    checkOutput("mode_after_vs", modeActive, 2'b01);
    applyStimulus(255, 0, 0, 3'b001, 2'b01);

    // Walking one on the syncs with a pixel ramp.
    for (int i = 0; i < 12; i++) begin
      walk = 3'(1 << (i % 3));
      applyStimulus(i * 20, 255 - i * 10, i * 7, walk, 2'b01);
    end

    // Reset mid-ramp clears the outputs without waiting for a clock.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_y", y, 0);
    checkOutput("async_cb", cb, 0);
    checkOutput("async_cr", cr, 0);
    checkOutput("async_de", deOut, 0);
    checkOutput("async_hs", hsOut, 0);
    checkOutput("async_mode", modeActive, 0);
    applyStimulus(100, 100, 100, 3'b101, 2'b01);
    applyStimulus(100, 100, 100, 3'b101, 2'b01);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(30 + i, 60 + i, 90 + i, 3'b001, 2'b00);
    end

    // DW=10 instance.
    @(negedge clk);
    r10 = 10'd1023; g10 = 10'd1023; b10 = 10'd1023;
    repeat (4) @(negedge clk);
    checkOutput("d10_white_y", y10, 1023);
    checkOutput("d10_white_cb", cb10, 512);
    checkOutput("d10_white_cr", cr10, 512);
    checkOutput("d10_de", deOut10, 0);
    checkOutput("d10_hs", hsOut10, 0);
    checkOutput("d10_mode_full", modeActive10, 2'b00);
    vs10 = 1'b1; range10 = 1'b1;
    @(negedge clk);
    vs10 = 1'b0; r10 = '0; g10 = '0; b10 = '0;
    repeat (4) @(negedge clk);
    checkOutput("d10_black_y", y10, 64);
    checkOutput("d10_black_cb", cb10, 512);
    checkOutput("d10_black_cr", cr10, 512);
    checkOutput("d10_mode_lim", modeActive10, 2'b10);
    checkOutput("d10_vs", vsOut10, 0);
    @(negedge clk);
    r10 = 10'd700; g10 = 10'd33; b10 = 10'd512;
    repeat (4) @(negedge clk);
    modelPixel(10, 2'b10, 700, 33, 512, ey, ecb, ecr);
    checkOutput("d10_mix_y", y10, ey);
    checkOutput("d10_mix_cb", cb10, ecb);
    checkOutput("d10_mix_cr", cr10, ecr);

    // Random pixels and syncs; selections wander and vsync pulses now and then.
    curSel = 2'b00;
    for (int i = 0; i < 240; i++) begin
      if (i % 20 == 0) curSel = 2'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                    {1'($urandom_range(0, 1)), (i % 20 == 7), 1'($urandom_range(0, 1))},
                    curSel);
    end

    // Let the last pixels drain.
    repeat (6) applyStimulus(0, 0, 0, 3'b000, curSel);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule
